// File: rtl/seven_segment_scan_driver_if.sv
// Connection bundle between a datapath that publishes digit frames and the
// multiplexed 7-segment scan driver that lights the board pins.
interface seven_segment_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    lz_suppress;
  logic                    load_ack;
  logic [6:0]              seg;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an;
  logic [IDX_W-1:0]        digit_idx;

  // The datapath side publishes frames and watches the acknowledge.
  modport master (
    output load, value, dp_in, blank_mask, lz_suppress,
    input  load_ack, seg, dp_out, an, digit_idx
  );

  modport slave (
    input  load, value, dp_in, blank_mask, lz_suppress,
    output load_ack, seg, dp_out, an, digit_idx
  );
endinterface

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: double-buffered frame, hex/BCD
// decode, leading-zero suppression, anti-ghost dead time, registered pin outputs.
module seven_segment_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 8,
  parameter bit HEX_MODE     = 1'b1,
  parameter bit SEG_ACT_LOW  = 1'b0,
  parameter bit AN_ACT_LOW   = 1'b0
) (
  input logic                        clk,
  input logic                        rst,
  seven_segment_scan_driver_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);

  localparam logic [PRE_W-1:0]      PRE_LAST  = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0]      PRE_BLANK = PRE_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF   = {7{SEG_ACT_LOW}};
  localparam logic                  DP_OFF    = SEG_ACT_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{AN_ACT_LOW}};

  logic [PRE_W-1:0]        prescaler;
  logic [IDX_W-1:0]        digit_idx;
  logic                    tick;
  logic                    frame_end;
  logic                    dead;

  logic [4*NUM_DIGITS-1:0] act_value;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [NUM_DIGITS-1:0]   act_blank;
  logic [4*NUM_DIGITS-1:0] pend_value;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [NUM_DIGITS-1:0]   pend_blank;
  logic                    pend;
  logic                    load_ack_q;

  logic [NUM_DIGITS-1:0]   zero_from;
  logic [3:0]              cur_code;
  logic                    cur_dp;
  logic                    cur_blank;
  logic                    cur_lz;
  logic [NUM_DIGITS-1:0]   cur_sel;

  logic [6:0]              seg_next;
  logic                    dp_next;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   an_q;

  function automatic logic [6:0] decode7(input logic [3:0] code);
    logic [6:0] s;
    s = 7'h00;
    case (code)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    if (!HEX_MODE && code > 4'd9) s = 7'h00;
    return s;
  endfunction

  always_comb begin
    tick      = (prescaler == PRE_LAST);
    frame_end = tick && (digit_idx == IDX_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      digit_idx <= '0;
    end else if (tick) begin
      prescaler <= '0;
      digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // The active frame only moves at frame_end, so a scan pass never mixes two frames.
  // A load landing exactly on frame_end bypasses the pending buffer and wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_value  <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend       <= 1'b0;
      load_ack_q <= 1'b0;
    end else begin
      load_ack_q <= 1'b0;
      if (frame_end && bus.load) begin
        act_value  <= bus.value;
        act_dp     <= bus.dp_in;
        act_blank  <= bus.blank_mask;
        pend       <= 1'b0;
        load_ack_q <= 1'b1;
      end else if (frame_end && pend) begin
        act_value  <= pend_value;
        act_dp     <= pend_dp;
        act_blank  <= pend_blank;
        pend       <= 1'b0;
        load_ack_q <= 1'b1;
      end else if (bus.load) begin
        pend_value <= bus.value;
        pend_dp    <= bus.dp_in;
        pend_blank <= bus.blank_mask;
        pend       <= 1'b1;
      end
    end
  end

  // zero_from[i] is set when every active digit from i up to the top is code 0.
  always_comb begin
    logic run;
    run       = 1'b1;
    zero_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run          = run && (act_value[4*i +: 4] == 4'h0);
      zero_from[i] = run;
    end
  end

  always_comb begin
    cur_code  = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_lz    = 1'b0;
    cur_sel   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        cur_code   = act_value[4*i +: 4];
        cur_dp     = act_dp[i];
        cur_blank  = act_blank[i];
        cur_lz     = bus.lz_suppress && zero_from[i] && (i != 0);
        cur_sel[i] = 1'b1;
      end
    end
  end

  if (BLANK_CYCLES == 0) begin : g_no_dead
    assign dead = 1'b0;
  end else begin : g_dead
    assign dead = (prescaler < PRE_BLANK);
  end

  // An LZ-blanked digit still shows its decimal point; a masked digit does not.
  always_comb begin
    seg_next = SEG_OFF;
    dp_next  = DP_OFF;
    an_next  = AN_OFF;
    if (!dead) begin
      an_next = cur_sel ^ AN_OFF;
      if (!cur_blank) begin
        seg_next = (cur_lz ? 7'h00 : decode7(cur_code)) ^ SEG_OFF;
        dp_next  = cur_dp ^ DP_OFF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG_OFF;
      dp_q  <= DP_OFF;
      an_q  <= AN_OFF;
    end else begin
      seg_q <= seg_next;
      dp_q  <= dp_next;
      an_q  <= an_next;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.dp_out    = dp_q;
  assign bus.an        = an_q;
  assign bus.digit_idx = digit_idx;
  assign bus.load_ack  = load_ack_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Directed bench: two drivers (active-high hex, active-low BCD) share one stimulus
// stream; edge numbers after reset release locate every digit slot.
module tb_seven_segment_scan_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edges = 0;
  int   checks = 0;
  int   errors = 0;

  seven_segment_scan_driver_if #(.NUM_DIGITS(4)) bus0 ();
  seven_segment_scan_driver_if #(.NUM_DIGITS(4)) bus1 ();

  seven_segment_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(10), .BLANK_CYCLES(2),
    .HEX_MODE(1'b1), .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b0)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
  );

  seven_segment_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(10), .BLANK_CYCLES(2),
    .HEX_MODE(1'b0), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
  ) u_dut_inv (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic stepTo(input int target);
    while (edges < target) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  // Slot (frame f, digit d, dwell phase p) is visible just after this edge.
  function automatic int slotEdge(input int f, input int d, input int p);
    return 40 * f + 10 * d + p + 1;
  endfunction

  task automatic applyStimulus(input logic [15:0] val, input logic [3:0] dp, input logic [3:0] bm);
    bus0.load = 1'b1; bus0.value = val; bus0.dp_in = dp; bus0.blank_mask = bm;
    bus1.load = 1'b1; bus1.value = val; bus1.dp_in = dp; bus1.blank_mask = bm;
    @(posedge clk);
    #1;
    edges++;
    bus0.load = 1'b0;
    bus1.load = 1'b0;
  endtask

  task automatic setLz(input logic lz);
    bus0.lz_suppress = lz;
    bus1.lz_suppress = lz;
  endtask

  task automatic checkSlot(input string tag, input logic [6:0] seg, input logic [3:0] an, input logic dp);
    checkOutput({tag, ".seg"}, bus0.seg, seg);
    checkOutput({tag, ".an"}, bus0.an, an);
    checkOutput({tag, ".dp"}, bus0.dp_out, dp);
  endtask

  task automatic checkSlotInv(input string tag, input logic [6:0] seg, input logic [3:0] an, input logic dp);
    checkOutput({tag, ".seg_inv"}, bus1.seg, seg);
    checkOutput({tag, ".an_inv"}, bus1.an, an);
    checkOutput({tag, ".dp_inv"}, bus1.dp_out, dp);
  endtask

  task automatic checkResetState(input string tag);
    checkSlot(tag, 7'h00, 4'b0000, 1'b0);
    checkOutput({tag, ".ack"}, bus0.load_ack, 1'b0);
    checkOutput({tag, ".idx"}, bus0.digit_idx, 2'd0);
    checkSlotInv(tag, 7'h7F, 4'b1111, 1'b1);
  endtask

  initial begin
    bus0.load = 1'b0; bus0.value = '0; bus0.dp_in = '0; bus0.blank_mask = '0;
    bus1.load = 1'b0; bus1.value = '0; bus1.dp_in = '0; bus1.blank_mask = '0;
    setLz(1'b0);

    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    rst   = 1'b0;
    edges = 0;

    // Scan timing against the all-zero power-up frame.
    stepTo(2);  checkSlot("dead_p1", 7'h00, 4'b0000, 1'b0);
    stepTo(3);  checkSlot("d0_p2", 7'h3F, 4'b0001, 1'b0);
    stepTo(9);  checkOutput("idx_pre_tick", bus0.digit_idx, 2'd0);
    stepTo(10); checkOutput("idx_post_tick", bus0.digit_idx, 2'd1);

    // Hex frame 12AF with dp on digit 2.
    applyStimulus(16'h12AF, 4'b0100, 4'b0000);
    stepTo(39); checkOutput("ack_before_fe", bus0.load_ack, 1'b0);
    stepTo(40); checkOutput("ack_at_fe", bus0.load_ack, 1'b1);
    stepTo(41);
    checkOutput("ack_one_cycle", bus0.load_ack, 1'b0);
    checkSlot("f1_dead", 7'h00, 4'b0000, 1'b0);
    stepTo(slotEdge(1, 0, 2));
    checkSlot("f1_d0", 7'h71, 4'b0001, 1'b0);
    checkSlotInv("f1_d0", 7'h7F, 4'b1110, 1'b1);
    stepTo(slotEdge(1, 1, 5)); checkSlot("f1_d1", 7'h77, 4'b0010, 1'b0);
    stepTo(slotEdge(1, 2, 3));
    checkSlot("f1_d2", 7'h5B, 4'b0100, 1'b1);
    checkSlotInv("f1_d2", 7'h24, 4'b1011, 1'b0);
    stepTo(slotEdge(1, 3, 9)); checkSlot("f1_d3", 7'h06, 4'b1000, 1'b0);

    // Leading-zero suppression on 0040 and then 0000.
    setLz(1'b1);
    applyStimulus(16'h0040, 4'b0000, 4'b0000);
    stepTo(slotEdge(3, 0, 4)); checkSlot("lz_d0", 7'h3F, 4'b0001, 1'b0);
    stepTo(slotEdge(3, 1, 4)); checkSlot("lz_d1", 7'h66, 4'b0010, 1'b0);
    stepTo(slotEdge(3, 2, 4)); checkSlot("lz_d2", 7'h00, 4'b0100, 1'b0);
    stepTo(slotEdge(3, 3, 4)); checkSlot("lz_d3", 7'h00, 4'b1000, 1'b0);
    applyStimulus(16'h0000, 4'b0010, 4'b0000);
    stepTo(slotEdge(4, 0, 4)); checkSlot("lz0_d0", 7'h3F, 4'b0001, 1'b0);
    stepTo(slotEdge(4, 1, 4)); checkSlot("lz0_d1_dp", 7'h00, 4'b0010, 1'b1);

    // Two loads in one frame: display holds, last one wins, single ack.
    applyStimulus(16'h1111, 4'b0000, 4'b0000);
    stepTo(slotEdge(4, 2, 4)); checkSlot("hold_d2", 7'h00, 4'b0100, 1'b0);
    setLz(1'b0);
    applyStimulus(16'h2222, 4'b0000, 4'b0000);
    stepTo(slotEdge(4, 3, 4)); checkSlot("hold_d3", 7'h3F, 4'b1000, 1'b0);
    stepTo(199); checkOutput("ack2_before", bus0.load_ack, 1'b0);
    stepTo(200); checkOutput("ack2_fe", bus0.load_ack, 1'b1);
    stepTo(201); checkOutput("ack2_single", bus0.load_ack, 1'b0);
    stepTo(slotEdge(5, 0, 4)); checkSlot("last_wins_d0", 7'h5B, 4'b0001, 1'b0);
    stepTo(slotEdge(5, 3, 4)); checkSlot("last_wins_d3", 7'h5B, 4'b1000, 1'b0);

    // Load on the frame_end cycle supersedes an older pending frame.
    applyStimulus(16'h3333, 4'b0000, 4'b0000);
    stepTo(239);
    applyStimulus(16'h9A87, 4'b0000, 4'b1000);
    checkOutput("ack_coincident", bus0.load_ack, 1'b1);
    stepTo(slotEdge(6, 0, 4));
    checkSlot("co_d0", 7'h07, 4'b0001, 1'b0);
    checkSlotInv("co_d0", 7'h78, 4'b1110, 1'b1);
    stepTo(slotEdge(6, 1, 4)); checkSlotInv("co_d1", 7'h00, 4'b1101, 1'b1);
    stepTo(slotEdge(6, 2, 4));
    checkSlot("co_d2", 7'h77, 4'b0100, 1'b0);
    checkSlotInv("bcd_code_a", 7'h7F, 4'b1011, 1'b1);
    stepTo(slotEdge(6, 3, 4)); checkSlot("mask_d3", 7'h00, 4'b1000, 1'b0);
    stepTo(280); checkOutput("dropped_no_ack", bus0.load_ack, 1'b0);
    stepTo(281);

    // Reset mid-dwell with a frame pending.
    applyStimulus(16'h4444, 4'b0000, 4'b0000);
    stepTo(285);
    rst = 1'b1;
    stepTo(286);
    checkResetState("midreset");
    rst   = 1'b0;
    edges = 0;
    stepTo(40); checkOutput("no_ack_after_rst", bus0.load_ack, 1'b0);
    stepTo(slotEdge(1, 0, 4)); checkSlot("post_rst_d0", 7'h3F, 4'b0001, 1'b0);
    stepTo(slotEdge(1, 3, 4)); checkSlot("post_rst_d3", 7'h3F, 4'b1000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
